// File: rtl/debounce_sync.sv
// Debouncer for a bouncy asynchronous input: a multi-flop synchroniser feeds a
// four-state qualification FSM that emits a clean level plus rise/fall strobes.
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d_raw,
  output logic d_clean,
  output logic rise,
  output logic fall,
  output logic busy
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_sync: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("debounce_sync: DEBOUNCE_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], d_raw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Strobes default low every cycle; busy tracks the state being entered.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= STABLE_LOW;
      cnt     <= '0;
      d_clean <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state)
        STABLE_LOW: begin
          if (s) begin
            state <= CHECK_HIGH;
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
          end else begin
            cnt   <= '0;
          end
        end
        CHECK_HIGH: begin
          if (!s) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state   <= STABLE_HIGH;
            cnt     <= '0;
            d_clean <= 1'b1;
            rise    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            state <= CHECK_LOW;
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
          end else begin
            cnt   <= '0;
          end
        end
        CHECK_LOW: begin
          if (s) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state   <= STABLE_LOW;
            cnt     <= '0;
            d_clean <= 1'b0;
            fall    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: reset vector table, hand-written corner sequences,
// then random bounce traffic against a run-length reference model.
module tb_debounce_sync;
  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int LAT  = SYNC + DEB;

  logic clock = 1'b0;
  logic reset_n, d_raw;
  logic d_clean, rise, fall, busy;

  debounce_sync #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock(clock), .reset_n(reset_n), .d_raw(d_raw),
    .d_clean(d_clean), .rise(rise), .fall(fall), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_rise, n_fall, n_busy, last_rise, last_fall;

  // Reference model: s is the raw input delayed SYNC edges; the clean level
  // flips once DEB consecutive samples disagree with it.
  bit mq[$];
  bit m_lvl, m_rise, m_fall, m_busy;
  int m_run;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic d);
    bit s;
    if (!r) begin
      mq.delete();
      for (int i = 0; i < SYNC; i++) mq.push_back(1'b0);
      m_lvl = 0; m_run = 0; m_rise = 0; m_fall = 0; m_busy = 0;
    end else begin
      s = mq.pop_front();
      mq.push_back(d);
      m_rise = 0; m_fall = 0;
      if (s != m_lvl) begin
        m_run++;
        if (m_run == DEB) begin
          m_lvl  = s;
          m_rise = s;
          m_fall = !s;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
      m_busy = (m_run != 0);
    end
  endtask

  task automatic tick(input logic r, input logic d);
    reset_n = r;
    d_raw   = d;
    model_step(r, d);
    @(posedge clock);
    #1;
    cyc++;
    check("m_clean", d_clean, m_lvl);
    check("m_rise",  rise,    m_rise);
    check("m_fall",  fall,    m_fall);
    check("m_busy",  busy,    m_busy);
    if (rise === 1'b1) begin n_rise++; last_rise = cyc; end
    if (fall === 1'b1) begin n_fall++; last_fall = cyc; end
    if (busy === 1'b1) n_busy++;
  endtask

  task automatic clr();
    n_rise = 0; n_fall = 0; n_busy = 0; last_rise = -1; last_fall = -1;
  endtask

  task automatic hold(input logic d, input int n);
    for (int i = 0; i < n; i++) tick(1'b1, d);
  endtask

  typedef struct {
    logic rst_n, d;
    logic e_clean, e_rise, e_fall, e_busy;
  } vec_t;
  vec_t tbl[23];

  initial begin
    int t0;
    logic lvl;
    reset_n = 1'b0;
    d_raw   = 1'b0;
    clr();

    // Reset with d_raw=1 held, then release: edge k after release
    for (int i = 0; i < 23; i++) begin
      int k;
      k = i - 2;
      tbl[i].d = 1'b1;
      if (i < 3) begin
        tbl[i].rst_n = 1'b0;
        tbl[i].e_clean = 0; tbl[i].e_rise = 0; tbl[i].e_fall = 0; tbl[i].e_busy = 0;
      end else begin
        tbl[i].rst_n   = 1'b1;
        tbl[i].e_clean = (k >= LAT);
        tbl[i].e_rise  = (k == LAT);
        tbl[i].e_fall  = 1'b0;
        tbl[i].e_busy  = (k >= SYNC + 1) && (k <= LAT - 1);
      end
    end
    for (int i = 0; i < 23; i++) begin
      tick(tbl[i].rst_n, tbl[i].d);
      check("tbl_clean", d_clean, tbl[i].e_clean);
      check("tbl_rise",  rise,    tbl[i].e_rise);
      check("tbl_fall",  fall,    tbl[i].e_fall);
      check("tbl_busy",  busy,    tbl[i].e_busy);
    end

    // Clean 0->1 step from STABLE_LOW
    tick(1'b0, 1'b0);
    hold(1'b0, 20);
    clr();
    t0 = cyc + 1;
    hold(1'b1, 25);
    check_int("step_rise_cnt", n_rise, 1);
    check_int("step_rise_edge", last_rise - t0 + 1, LAT);
    check_int("step_fall_cnt", n_fall, 0);
    check_int("step_busy_len", n_busy, DEB - 1);
    check("step_clean", d_clean, 1'b1);

    // Clean 1->0 step from STABLE_HIGH
    clr();
    t0 = cyc + 1;
    hold(1'b0, 25);
    check_int("fstep_fall_cnt", n_fall, 1);
    check_int("fstep_fall_edge", last_fall - t0 + 1, LAT);
    check_int("fstep_rise_cnt", n_rise, 0);
    check("fstep_clean", d_clean, 1'b0);

    // Bounce train: 5 high / 3 low x4, then held high
    clr();
    for (int r = 0; r < 4; r++) begin
      hold(1'b1, 5);
      hold(1'b0, 3);
    end
    check_int("bounce_no_rise", n_rise, 0);
    t0 = cyc + 1;
    hold(1'b1, 25);
    check_int("bounce_rise_cnt", n_rise, 1);
    check_int("bounce_rise_edge", last_rise - t0 + 1, LAT);

    // Glitch one sample short of acceptance
    hold(1'b0, 25);
    clr();
    hold(1'b1, DEB - 1);
    hold(1'b0, 25);
    check_int("glitch_rise", n_rise, 0);
    check_int("glitch_fall", n_fall, 0);
    check("glitch_busy", busy, 1'b0);
    check("glitch_clean", d_clean, 1'b0);

    // Reset while in CHECK_HIGH with counter=10 abandons qualification
    clr();
    hold(1'b1, SYNC + 10);
    check("mid_busy_pre", busy, 1'b1);
    tick(1'b0, 1'b0);
    check("mid_busy_rst", busy, 1'b0);
    check("mid_clean_rst", d_clean, 1'b0);
    tick(1'b1, 1'b0);
    check("mid_busy_next", busy, 1'b0);
    check("mid_rise_next", rise, 1'b0);
    hold(1'b0, 40);
    check_int("mid_no_rise", n_rise, 0);

    // Random bounce traffic with occasional resets
    lvl = 1'b0;
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 49) == 0) tick(1'b0, 1'($urandom_range(0, 1)));
      lvl = ~lvl;
      hold(lvl, $urandom_range(1, 24));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
